// File: rtl/apb_pkg.sv
// Shared APB slave definitions: access FSM states, bus widths and the error-response data value.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  localparam logic [APB_DATA_W-1:0] APB_ERR_DATA = 8'h00;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB completer-side bus bundle. The master modport drives the request; the slave modport answers it.
interface apb_slave_mem_if;
  import apb_pkg::*;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_ADDR_W-1:0] paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic [APB_DATA_W-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_slave_regfile.sv
// DEPTH x 8 register array with a synchronous write, an asynchronous read and a synchronous clear.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [APB_ADDR_W-1:0] i_addr,
  input  logic [APB_DATA_W-1:0] i_wdata,
  output logic [APB_DATA_W-1:0] o_rdata
);

  logic [APB_DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!i_rst_n) begin
        r_mem[i] <= '0;
      end else if (i_we && (i_addr == APB_ADDR_W'(i))) begin
        r_mem[i] <= i_wdata;
      end
    end
  end

  // Addresses beyond DEPTH match no entry and read back as zero.
  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_addr == APB_ADDR_W'(i)) begin
        o_rdata = r_mem[i];
      end
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with a byte-wide register memory, PSLVERR on out-of-range or setup-less accesses.
// Wait states come from WAIT_CYCLES only when APB_SLV_WAIT_EN is defined; otherwise every access is zero-wait.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           i_pclk,
  input  logic           i_presetn,
  apb_slave_mem_if.slave s_apb
);

  apb_state_e            r_state;
  apb_state_e            w_next_state;
  logic [APB_ADDR_W-1:0] r_addr;
  logic [APB_DATA_W-1:0] r_wdata;
  logic                  r_write;
  logic                  r_err;

  logic                  w_setup;
  logic                  w_addr_err;
  logic                  w_cnt_zero;
  logic                  w_we;
  logic                  w_ready;
  logic                  w_slverr;
  logic [APB_DATA_W-1:0] w_prdata;
  logic [APB_DATA_W-1:0] w_rdata;

  assign w_setup    = (r_state == IDLE) && s_apb.psel && !s_apb.penable;
  assign w_addr_err = ({1'b0, s_apb.paddr} >= 9'(DEPTH));

`ifdef APB_SLV_WAIT_EN
  logic [3:0] r_cnt;

  always_ff @(posedge i_pclk) begin
    if (!i_presetn) begin
      r_cnt <= '0;
    end else if (w_setup) begin
      r_cnt <= 4'(WAIT_CYCLES);
    end else if ((r_state == ACCESS) && s_apb.psel && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign w_cnt_zero = (r_cnt == 4'd0);
`else
  assign w_cnt_zero = 1'b1;
`endif

  // Request fields are frozen at the setup phase; later bus changes are ignored.
  always_ff @(posedge i_pclk) begin
    if (!i_presetn) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_setup) begin
        r_addr  <= s_apb.paddr;
        r_wdata <= s_apb.pwdata;
        r_write <= s_apb.pwrite;
        r_err   <= w_addr_err;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_slverr     = 1'b0;
    w_prdata     = APB_ERR_DATA;
    w_we         = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_apb.psel) begin
          if (!s_apb.penable) begin
            w_next_state = ACCESS;
          end else begin
            w_ready  = 1'b1;
            w_slverr = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (!s_apb.psel) begin
          w_next_state = IDLE;
        end else if (w_cnt_zero) begin
          w_ready      = 1'b1;
          w_next_state = IDLE;
          if (r_err) begin
            w_slverr = 1'b1;
          end else if (r_write) begin
            w_we = 1'b1;
          end else begin
            w_prdata = w_rdata;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  apb_slave_regfile #(
    .DEPTH (DEPTH)
  ) u_regfile (
    .i_clk   (i_pclk),
    .i_rst_n (i_presetn),
    .i_we    (w_we),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign s_apb.pready  = w_ready;
  assign s_apb.pslverr = w_slverr;
  assign s_apb.prdata  = w_prdata;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: directed vector table, multi-cycle corner sequences and randomized
// transfers against a byte-array reference model. Expected wait states follow APB_SLV_WAIT_EN.
module tb_apb_slave_mem;
  import apb_pkg::*;

  localparam int DEPTH       = 64;
  localparam int WAIT_CYCLES = 2;
`ifdef APB_SLV_WAIT_EN
  localparam int EFF_WAIT = WAIT_CYCLES;
`else
  localparam int EFF_WAIT = 0;
`endif

  typedef struct {
    logic       isWrite;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] expRdata;
    logic       expErr;
  } vec_t;

  logic clock = 1'b0;
  logic presetn;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] model [256];

  always #5 clock = ~clock;

  apb_slave_mem_if bus();

  apb_slave_mem #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .i_pclk    (clock),
    .i_presetn (presetn),
    .s_apb     (bus.slave)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference behaviour: in-range writes land in the array, in-range reads return it, anything else errors with 0.
  function automatic void modelAccess(input logic w, input logic [7:0] a, input logic [7:0] d,
                                      output logic [7:0] expRd, output logic expErr);
    expErr = (int'(a) >= DEPTH);
    expRd  = 8'h00;
    if (!expErr) begin
      if (w) model[a] = d;
      else   expRd = model[a];
    end
  endfunction

  task automatic resetDut();
    @(posedge clock); #1;
    presetn     = 1'b0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    repeat (2) @(posedge clock);
    #1 presetn = 1'b1;
    model = '{default: 8'h00};
  endtask

  task automatic idleCycle();
    @(posedge clock); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  // One full transfer; bus fields are scrambled during the access phase to prove they are latched.
  task automatic applyStimulus(input logic isWrite, input logic [7:0] addr, input logic [7:0] data,
                               output logic [7:0] rdata, output logic err, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    rdata = 8'h00;
    err   = 1'b0;
    @(posedge clock); #1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = isWrite;
    bus.paddr   = addr;
    bus.pwdata  = data;
    @(negedge clock);
    checkOutput("setup_pready", 32'(bus.pready), 32'd0);
    for (int c = 0; c < 32 && !done; c++) begin
      @(posedge clock); #1;
      bus.penable = 1'b1;
      bus.pwrite  = 1'($urandom);
      bus.paddr   = 8'($urandom);
      bus.pwdata  = 8'($urandom);
      @(negedge clock);
      if (bus.pready) begin
        rdata = bus.prdata;
        err   = bus.pslverr;
        done  = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL transfer_timeout: got no PREADY, expected PREADY within 32 cycles");
    end
  endtask

  task automatic runChecked(input string name, input logic w, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] expRd, input logic expErr);
    logic [7:0] rd;
    logic       err;
    int         waits;
    applyStimulus(w, a, d, rd, err, waits);
    checkOutput({name, "_prdata"}, 32'(rd), 32'(expRd));
    checkOutput({name, "_pslverr"}, 32'(err), 32'(expErr));
    checkOutput({name, "_waits"}, 32'(waits), 32'(EFF_WAIT));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t       table_v [14];
    logic [7:0] expRd;
    logic       expErr;
    logic       w;
    logic [7:0] a;
    logic [7:0] d;

    table_v[0]  = '{1'b1, 8'h03, 8'hA5, 8'h00, 1'b0};
    table_v[1]  = '{1'b0, 8'h03, 8'h00, 8'hA5, 1'b0};
    table_v[2]  = '{1'b0, 8'h40, 8'h00, 8'h00, 1'b1};
    table_v[3]  = '{1'b0, 8'h3F, 8'h00, 8'h00, 1'b0};
    table_v[4]  = '{1'b1, 8'h00, 8'h11, 8'h00, 1'b0};
    table_v[5]  = '{1'b1, 8'h01, 8'h22, 8'h00, 1'b0};
    table_v[6]  = '{1'b0, 8'h00, 8'h00, 8'h11, 1'b0};
    table_v[7]  = '{1'b0, 8'h01, 8'h00, 8'h22, 1'b0};
    table_v[8]  = '{1'b1, 8'h40, 8'hEE, 8'h00, 1'b1};
    table_v[9]  = '{1'b1, 8'h3F, 8'hC3, 8'h00, 1'b0};
    table_v[10] = '{1'b0, 8'h3F, 8'h00, 8'hC3, 1'b0};
    table_v[11] = '{1'b0, 8'hFF, 8'h00, 8'h00, 1'b1};
    table_v[12] = '{1'b1, 8'h03, 8'h5C, 8'h00, 1'b0};
    table_v[13] = '{1'b0, 8'h03, 8'h00, 8'h5C, 1'b0};

    presetn     = 1'b1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = 8'h00;
    bus.pwdata  = 8'h00;

    resetDut();
    @(negedge clock);
    checkOutput("reset_pready", 32'(bus.pready), 32'd0);
    checkOutput("reset_pslverr", 32'(bus.pslverr), 32'd0);
    checkOutput("reset_prdata", 32'(bus.prdata), 32'd0);

    // Table entries run back-to-back with no idle cycle between transfers.
    for (int i = 0; i < 14; i++) begin
      modelAccess(table_v[i].isWrite, table_v[i].addr, table_v[i].data, expRd, expErr);
      runChecked($sformatf("vec%0d", i), table_v[i].isWrite, table_v[i].addr, table_v[i].data,
                 table_v[i].expRdata, table_v[i].expErr);
    end
    idleCycle();

    // Aborted write: PSEL drops in the first access cycle.
    @(posedge clock); #1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = 8'h05;
    bus.pwdata  = 8'h77;
    @(posedge clock); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    @(negedge clock);
    checkOutput("abort_pready", 32'(bus.pready), 32'd0);
    runChecked("abort_readback", 1'b0, 8'h05, 8'h00, 8'h00, 1'b0);
    idleCycle();

    // Access phase with no preceding setup.
    @(posedge clock); #1;
    bus.psel    = 1'b1;
    bus.penable = 1'b1;
    bus.pwrite  = 1'b1;
    bus.paddr   = 8'h06;
    bus.pwdata  = 8'h99;
    @(negedge clock);
    checkOutput("nosetup_pready", 32'(bus.pready), 32'd1);
    checkOutput("nosetup_pslverr", 32'(bus.pslverr), 32'd1);
    checkOutput("nosetup_prdata", 32'(bus.prdata), 32'd0);
    idleCycle();
    @(negedge clock);
    checkOutput("idle_pready", 32'(bus.pready), 32'd0);
    runChecked("nosetup_readback", 1'b0, 8'h06, 8'h00, 8'h00, 1'b0);

    // Reset asserted in the middle of an access.
    modelAccess(1'b1, 8'h02, 8'h5A, expRd, expErr);
    runChecked("pre_reset_write", 1'b1, 8'h02, 8'h5A, 8'h00, 1'b0);
    runChecked("pre_reset_read", 1'b0, 8'h02, 8'h00, 8'h5A, 1'b0);
    @(posedge clock); #1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = 8'h02;
    bus.pwdata  = 8'h66;
    @(posedge clock); #1;
    bus.penable = 1'b1;
    presetn     = 1'b0;
    @(posedge clock); #1;
    presetn     = 1'b1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    model = '{default: 8'h00};
    @(negedge clock);
    checkOutput("midreset_pready", 32'(bus.pready), 32'd0);
    runChecked("midreset_readback", 1'b0, 8'h02, 8'h00, 8'h00, 1'b0);

    // Randomized traffic concentrated on a few addresses so reads hit earlier writes.
    for (int i = 0; i < 80; i++) begin
      w = 1'($urandom);
      d = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       a = 8'($urandom_range(DEPTH, 255));
        1:       a = 8'(DEPTH - 1);
        default: a = 8'($urandom_range(0, 7));
      endcase
      modelAccess(w, a, d, expRd, expErr);
      runChecked($sformatf("rand%0d", i), w, a, d, expRd, expErr);
      if ($urandom_range(0, 3) == 0) idleCycle();
    end
    idleCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer (slave) that sits directly downstream of the APB master bridge and answers one of its two select lines (PSEL1 or PSEL2) with a byte-wide register memory. It decodes the setup and access phases and inserts a configurable number of wait states via PREADY. It flags out-of-range or protocol-violating accesses on PSLVERR, and returns read data on PRDATA. Two instances, one per select line, form the complete slave side of the bus.

## Interface
- DEPTH, 64: number of byte locations; valid addresses are 0..DEPTH-1; must be ≤ 256.
- WAIT_CYCLES, 2: wait states inserted before PREADY in every access phase; range 0..15.

Ports:
- PCLK  in  1  bus clock; the only clock.
- PRESETn  in  1  reset; synchronous, active-low.
- PSEL  in  1  select, wired to PSEL1 or PSEL2 of the master.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  8  byte address, wired to master PADDR[7:0]; PADDR[8] is already decoded into PSEL.
- PWDATA  in  8  write data.
- PRDATA  out  8  read data.
- PREADY  out  1  transfer-complete / wait-state control.
- PSLVERR  out  1  transfer error; valid only while PREADY=1.

## Operation
FSM states (package enum): IDLE, ACCESS.

- **IDLE**
  - PSEL=1 and PENABLE=0 (setup phase):
    - Latch PADDR, PWRITE and PWDATA.
    - Load the wait counter with WAIT_CYCLES.
    - Set the error flag if PADDR ≥ DEPTH.
    - Go to ACCESS.
  - PSEL=1 and PENABLE=1 with no preceding setup (protocol violation): assert PREADY=1 and PSLVERR=1 in that cycle, with no write and PRDATA=0. Stay in IDLE.
- **ACCESS**
  - PSEL=0 (abort): return to IDLE with no write.
  - Counter ≠ 0: PREADY=0; decrement the counter.
  - Counter = 0: PREADY=1 and the transfer completes at this edge.
    - Write with no error: the latched PWDATA is stored at the latched address.
    - Read with no error: PRDATA = mem[latched address].
    - Error: no store, PRDATA=0, PSLVERR=1.
    - Next state is IDLE.
- The latched address, direction and data are used throughout the access. Changes on PADDR, PWRITE or PWDATA after the setup phase are ignored.
- Memory reads are asynchronous from the register array. Writes are synchronous.

## Timing
- Reset (PRESETn=0 at a PCLK edge):
  - State goes to IDLE and the counter to 0.
  - All memory locations are cleared to 0x00.
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - Reset applied mid-access aborts the access with no write.
- PREADY, PSLVERR and PRDATA are combinational from state, counter and latched flags. They are 0 whenever no transfer is completing.
- Latency:
  - The setup phase takes 1 cycle.
  - The access phase takes WAIT_CYCLES+1 cycles.
  - WAIT_CYCLES=0 gives zero-wait operation (PREADY=1 in the first access cycle).
- Back-to-back: a setup phase in the cycle immediately after completion is captured from IDLE, with no bubble.
- Write-then-read of the same address on consecutive transfers returns the new data.
- Address DEPTH-1 is valid; address DEPTH is an error. No wrap-around.

## Configuration
- APB_SLV_WAIT_EN:
  - Defined: the wait counter and WAIT_CYCLES are honoured as above.
  - Undefined: the counter logic is removed and WAIT_CYCLES is ignored. PREADY=1 in the first ACCESS cycle (zero-wait only); all other behaviour is unchanged.

## Structure
- Shared package apb_pkg holds:
  - the FSM state enum (IDLE, ACCESS);
  - APB_ADDR_W=8 and APB_DATA_W=8;
  - the error-response data constant 8'h00.
- One sub-module, apb_slave_regfile:
  - DEPTH×8 register array;
  - synchronous write enable;
  - asynchronous read port;
  - synchronous clear on PRESETn.
- The FSM, counter, latches and response logic live in apb_slave_mem.

## Test plan
1. Reset, then write 0xA5 to address 0x03, then read 0x03 with WAIT_CYCLES=2 → PREADY low for 2 access cycles, high on the 3rd; PRDATA=0xA5; PSLVERR=0.
2. Read address 0x40 with DEPTH=64 → PREADY=1 with PSLVERR=1 and PRDATA=0x00. A following read of 0x3F returns 0x00, with memory unchanged.
3. Back-to-back writes 0x11→0x00 and 0x22→0x01 with no idle cycle, then reads of both → 0x11 and 0x22; no dropped setup.
4. PSEL deasserted during a write's wait state (address 0x05, data 0x77), then read 0x05 → 0x00; the aborted write is never stored.
5. PSEL=1 and PENABLE=1 from IDLE with no setup → PREADY=1 and PSLVERR=1 in the same cycle; no write.
6. PRESETn low mid-access after writing 0x5A to 0x02, then read 0x02 → 0x00. Rebuild without APB_SLV_WAIT_EN: every access completes with PREADY=1 in the first access cycle.
